group_scan_mem_reg_if_p: RTL and testbench

Parametrised group-level bridge between the group mux static bus and one group's local SRAM plus a bank of NUM_CTR control registers. It synchronises the asynchronous scan_id select and admits a static request only while its group is selected. It decodes the address to SRAM or one control register and runs a request/ready handshake toward that target. Adds a completion timeout, decode/protocol error reporting and a four-phase return handshake.

---
 rtl/group_scan_mem_reg_if_p.sv | 253 +++++++++++++++++++++++++
 tb/tb_group_scan_mem_reg_if_p.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/group_scan_mem_reg_if_p.sv
// group_scan_mem_reg_if_p
//   Group-level bridge from the group mux static bus to one group's local
//   SRAM and a bank of NUM_CTR control registers.
//   A request is accepted only while the synchronised scan_id is high.
//   The address is decoded to SRAM or to one control register.
//   A request/ready handshake is then run toward the decoded target,
//   bounded by a completion timeout. The result is returned as a one-cycle
//   static_ready pulse. The bridge then waits for the request to be released.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   scan_id                group select (asynchronous, synchronised here)
//   static_wen/ren/addr/wdata   level request, held until static_ready
//   static_rdata/ready/err response (rdata/err hold until the next response)
//   sram_*                 SRAM strobe/address/data and ready
//   ctr_*                  control register strobes, one-hot select, ready
module group_scan_mem_reg_if_p #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 20,
    parameter int SRAM_AW = 11,
    parameter int NUM_CTR = 2,
    parameter int CTR_W   = 17,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      scan_id,
    input  logic                      static_wen,
    input  logic                      static_ren,
    input  logic [ADDR_W-1:0]         static_addr,
    input  logic [DATA_W-1:0]         static_wdata,
    output logic [DATA_W-1:0]         static_rdata,
    output logic                      static_ready,
    output logic                      static_err,
    output logic                      sram_ren,
    output logic                      sram_wen,
    output logic [SRAM_AW-1:0]        sram_addr,
    output logic [DATA_W-1:0]         sram_wdata,
    input  logic [DATA_W-1:0]         sram_rdata,
    input  logic                      sram_ready,
    output logic                      ctr_ren,
    output logic                      ctr_wen,
    output logic [NUM_CTR-1:0]        ctr_sel,
    output logic [CTR_W-1:0]          ctr_wdata,
    input  logic [NUM_CTR*CTR_W-1:0]  ctr_rdata,
    input  logic                      ctr_ready
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, id_sync_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SRAM_AW:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wen_q, wen_d;
    logic                ren_q, ren_d;
    logic                sram_ren_q, sram_ren_d;
    logic                sram_wen_q, sram_wen_d;
    logic                ctr_ren_q, ctr_ren_d;
    logic                ctr_wen_q, ctr_wen_d;
    logic [NUM_CTR-1:0]  ctr_sel_q, ctr_sel_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ready_q, ready_d;

    // Decode of the captured address
    logic                is_ctr;
    logic [3:0]          idx;
    logic                idx_bad;
    logic                tgt_ready;
    logic [CTR_W-1:0]    ctr_word;
    logic [NUM_CTR-1:0]  ctr_sel_dec;
    logic [DATA_W-1:0]   ctr_ext;

    assign is_ctr    = addr_q[SRAM_AW];
    assign idx       = addr_q[3:0];
    assign idx_bad   = (32'(idx) >= 32'(NUM_CTR));
    assign tgt_ready = is_ctr ? ctr_ready : sram_ready;

    // Address bits above the decode bit do not take part in the access.
    if (ADDR_W > SRAM_AW + 1) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^static_addr[ADDR_W-1:SRAM_AW+1];
    end

    always_comb begin
        ctr_word    = '0;
        ctr_sel_dec = '0;
        for (int unsigned i = 0; i < NUM_CTR; i++) begin
            if (idx == 4'(i)) begin
                ctr_word       = ctr_rdata[i*CTR_W +: CTR_W];
                ctr_sel_dec[i] = 1'b1;
            end
        end
        ctr_ext                = '0;
        ctr_ext[CTR_W-1:0]     = ctr_word;
    end

    // Two-flop synchroniser for the asynchronous group select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            id_sync_q <= 1'b0;
        end else begin
            sync1_q   <= scan_id;
            id_sync_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            ren_q      <= 1'b0;
            sram_ren_q <= 1'b0;
            sram_wen_q <= 1'b0;
            ctr_ren_q  <= 1'b0;
            ctr_wen_q  <= 1'b0;
            ctr_sel_q  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wen_q      <= wen_d;
            ren_q      <= ren_d;
            sram_ren_q <= sram_ren_d;
            sram_wen_q <= sram_wen_d;
            ctr_ren_q  <= ctr_ren_d;
            ctr_wen_q  <= ctr_wen_d;
            ctr_sel_q  <= ctr_sel_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wen_d      = wen_q;
        ren_d      = ren_q;
        sram_ren_d = sram_ren_q;
        sram_wen_d = sram_wen_q;
        ctr_ren_d  = ctr_ren_q;
        ctr_wen_d  = ctr_wen_q;
        ctr_sel_d  = ctr_sel_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        ready_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (id_sync_q && (static_wen || static_ren)) begin
                    addr_d  = static_addr[SRAM_AW:0];
                    wdata_d = static_wdata;
                    wen_d   = static_wen;
                    ren_d   = static_ren;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((wen_q && ren_q) || (is_ctr && idx_bad)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    if (is_ctr) begin
                        ctr_ren_d = ren_q;
                        ctr_wen_d = wen_q;
                        ctr_sel_d = ctr_sel_dec;
                    end else begin
                        sram_ren_d = ren_q;
                        sram_wen_d = wen_q;
                    end
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Ready is tested before the limit, so ready on the final
                // allowed cycle still completes successfully.
                if (tgt_ready) begin
                    if (!ren_q) begin
                        rdata_d = '0;
                    end else if (is_ctr) begin
                        rdata_d = ctr_ext;
                    end else begin
                        rdata_d = sram_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (state_d == S_RESP) begin
                    sram_ren_d = 1'b0;
                    sram_wen_d = 1'b0;
                    ctr_ren_d  = 1'b0;
                    ctr_wen_d  = 1'b0;
                    ctr_sel_d  = '0;
                    cnt_d      = '0;
                end
            end
            S_RESP: begin
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                // The request is level-held; wait for its release so the
                // same request is not accepted twice.
                if (!static_wen && !static_ren) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign static_rdata = rdata_q;
    assign static_err   = err_q;
    assign static_ready = ready_q;
    assign sram_ren     = sram_ren_q;
    assign sram_wen     = sram_wen_q;
    assign sram_addr    = addr_q[SRAM_AW-1:0];
    assign sram_wdata   = wdata_q;
    assign ctr_ren      = ctr_ren_q;
    assign ctr_wen      = ctr_wen_q;
    assign ctr_sel      = ctr_sel_q;
    assign ctr_wdata    = wdata_q[CTR_W-1:0];

endmodule

// File: tb/tb_group_scan_mem_reg_if_p.sv
// Testbench for group_scan_mem_reg_if_p: behavioural SRAM and control
// register responders, a response scoreboard and directed scenarios.
module tb_group_scan_mem_reg_if_p;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 20;
    localparam int SRAM_AW = 11;
    localparam int NUM_CTR = 2;
    localparam int CTR_W   = 17;
    localparam int TIMEOUT = 255;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic                      scan_id = 1'b0;
    logic                      static_wen = 1'b0;
    logic                      static_ren = 1'b0;
    logic [ADDR_W-1:0]         static_addr = '0;
    logic [DATA_W-1:0]         static_wdata = '0;
    logic [DATA_W-1:0]         static_rdata;
    logic                      static_ready;
    logic                      static_err;
    logic                      sram_ren, sram_wen;
    logic [SRAM_AW-1:0]        sram_addr;
    logic [DATA_W-1:0]         sram_wdata;
    logic [DATA_W-1:0]         sram_rdata;
    logic                      sram_ready = 1'b0;
    logic                      ctr_ren, ctr_wen;
    logic [NUM_CTR-1:0]        ctr_sel;
    logic [CTR_W-1:0]          ctr_wdata;
    logic [NUM_CTR*CTR_W-1:0]  ctr_rdata = '0;
    logic                      ctr_ready = 1'b0;

    group_scan_mem_reg_if_p #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .SRAM_AW(SRAM_AW),
        .NUM_CTR(NUM_CTR),
        .CTR_W  (CTR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_id     (scan_id),
        .static_wen  (static_wen),
        .static_ren  (static_ren),
        .static_addr (static_addr),
        .static_wdata(static_wdata),
        .static_rdata(static_rdata),
        .static_ready(static_ready),
        .static_err  (static_err),
        .sram_ren    (sram_ren),
        .sram_wen    (sram_wen),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata),
        .sram_ready  (sram_ready),
        .ctr_ren     (ctr_ren),
        .ctr_wen     (ctr_wen),
        .ctr_sel     (ctr_sel),
        .ctr_wdata   (ctr_wdata),
        .ctr_rdata   (ctr_rdata),
        .ctr_ready   (ctr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- SRAM model ----------------
    logic [DATA_W-1:0] mem [0:(1<<SRAM_AW)-1];
    assign sram_rdata = mem[sram_addr];

    int s_delay = 0;     // strobe cycles before ready; -1 never answers
    int s_cnt = 0;
    int s_acc = 0;
    int s_hi_total = 0;
    int s_last_hi = 0;
    logic [SRAM_AW-1:0] s_last_addr = '0;
    logic [DATA_W-1:0]  s_last_wdata = '0;
    logic               s_last_we = 1'b0;

    always @(negedge clk) begin
        if (sram_ren || sram_wen) begin
            s_hi_total++;
            if (s_cnt == s_delay) begin
                sram_ready   = 1'b1;
                s_acc++;
                s_last_addr  = sram_addr;
                s_last_wdata = sram_wdata;
                s_last_we    = sram_wen;
                if (sram_wen) mem[sram_addr] = sram_wdata;
            end else begin
                sram_ready = 1'b0;
            end
            s_cnt++;
        end else begin
            if (s_cnt != 0) s_last_hi = s_cnt;
            sram_ready = 1'b0;
            s_cnt      = 0;
        end
    end

    // ---------------- control register model ----------------
    int c_delay = 0;
    int c_cnt = 0;
    int c_acc = 0;
    int c_hi_total = 0;
    logic [NUM_CTR-1:0] c_last_sel = '0;
    logic [CTR_W-1:0]   c_last_wdata = '0;
    logic               c_last_we = 1'b0;

    always @(negedge clk) begin
        if (ctr_ren || ctr_wen) begin
            c_hi_total++;
            if (c_cnt == c_delay) begin
                ctr_ready    = 1'b1;
                c_acc++;
                c_last_sel   = ctr_sel;
                c_last_wdata = ctr_wdata;
                c_last_we    = ctr_wen;
            end else begin
                ctr_ready = 1'b0;
            end
            c_cnt++;
        end else begin
            ctr_ready = 1'b0;
            c_cnt     = 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (static_ready) begin
            if (sb.size() == 0) begin
                check_eq("spurious_ready", 64'(static_ready), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("resp_rdata", 64'(static_rdata), 64'(e.rdata));
                check_eq("resp_err", 64'(static_err), 64'(e.err));
            end
        end
    end

    // Drive one request, push its expected response, wait for static_ready,
    // keep the request held 'hold' extra cycles, then release it.
    // lat = edges from the accepting edge to the edge raising static_ready.
    task automatic do_req(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] er,
                          input logic ee, input int hold, output int lat);
        exp_t e;
        e.rdata = er;
        e.err   = ee;
        @(negedge clk);
        sb.push_back(e);
        static_wen   = w;
        static_ren   = r;
        static_addr  = a;
        static_wdata = d;
        lat = -1;
        for (int i = 1; i <= TIMEOUT + 20; i++) begin
            @(negedge clk);
            if (static_ready) begin
                lat = i - 1;
                break;
            end
        end
        if (lat < 0) begin
            check_eq("resp_timeout", 64'd0, 64'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        repeat (hold) @(negedge clk);
        static_wen = 1'b0;
        static_ren = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc0, hi0, first, rdy_seen;

        for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = 32'h0;
        mem[7] = 32'hCAFE0007;
        ctr_rdata[0*CTR_W +: CTR_W] = 17'h0F0F0;
        ctr_rdata[1*CTR_W +: CTR_W] = 17'h1ABCD;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 64'(static_ready), 64'd0);
        check_eq("rst_err", 64'(static_err), 64'd0);
        check_eq("rst_rdata", 64'(static_rdata), 64'd0);
        check_eq("rst_sram_strb", 64'({sram_ren, sram_wen}), 64'd0);
        check_eq("rst_ctr_strb", 64'({ctr_ren, ctr_wen}), 64'd0);
        check_eq("rst_ctr_sel", 64'(ctr_sel), 64'd0);
        rst_n   = 1'b1;
        scan_id = 1'b1;
        repeat (4) @(negedge clk);

        // SRAM write, ready one cycle after strobe; request held afterwards
        s_delay = 1;
        acc0 = s_acc;
        do_req(1'b1, 1'b0, 20'h00005, 32'hDEADBEEF, 32'h0, 1'b0, 5, lat);
        check_eq("wr_latency", 64'(lat), 64'd4);
        check_eq("wr_single_access", 64'(s_acc - acc0), 64'd1);
        check_eq("wr_sram_addr", 64'(s_last_addr), 64'd5);
        check_eq("wr_sram_wdata", 64'(s_last_wdata), 64'hDEADBEEF);
        check_eq("wr_sram_we", 64'(s_last_we), 64'd1);

        // SRAM read back, immediate ready: minimum latency
        s_delay = 0;
        do_req(1'b0, 1'b1, 20'h00005, 32'h0, 32'hDEADBEEF, 1'b0, 0, lat);
        check_eq("rd_latency", 64'(lat), 64'd3);

        // Control register read, index 1; upper address bits ignored
        c_delay = 0;
        hi0 = s_hi_total;
        do_req(1'b0, 1'b1, 20'hF0801, 32'h0, 32'h0001ABCD, 1'b0, 0, lat);
        check_eq("ctr_rd_latency", 64'(lat), 64'd3);
        check_eq("ctr_rd_sel", 64'(c_last_sel), 64'b10);
        check_eq("ctr_rd_no_sram", 64'(s_hi_total - hi0), 64'd0);

        // Control register write, index 0, ready after two cycles
        c_delay = 2;
        do_req(1'b1, 1'b0, 20'h00800, 32'h12345678, 32'h0, 1'b0, 0, lat);
        check_eq("ctr_wr_sel", 64'(c_last_sel), 64'b01);
        check_eq("ctr_wr_wdata", 64'(c_last_wdata), 64'h05678);
        check_eq("ctr_wr_we", 64'(c_last_we), 64'd1);
        check_eq("ctr_wr_latency", 64'(lat), 64'd5);

        // Group not selected: request must sit unserved
        scan_id = 1'b0;
        s_delay = 0;
        repeat (4) @(negedge clk);
        begin
            exp_t e;
            e.rdata = 32'hDEADBEEF;
            e.err   = 1'b0;
            sb.push_back(e);
        end
        hi0 = s_hi_total + c_hi_total;
        static_ren  = 1'b1;
        static_addr = 20'h00005;
        rdy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (static_ready) rdy_seen++;
        end
        check_eq("unsel_no_strobe", 64'(s_hi_total + c_hi_total - hi0), 64'd0);
        check_eq("unsel_no_ready", 64'(rdy_seen), 64'd0);
        scan_id = 1'b1;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sram_ren) begin
                first = i;
                break;
            end
        end
        check_eq("sel_strobe_edge", 64'(first), 64'd4);
        rdy_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (static_ready) begin
                rdy_seen = 1;
                break;
            end
        end
        check_eq("sel_resp_seen", 64'(rdy_seen), 64'd1);
        static_ren = 1'b0;
        repeat (2) @(negedge clk);

        // Decode error: register index out of range
        hi0 = s_hi_total + c_hi_total;
        do_req(1'b0, 1'b1, 20'h00803, 32'h0, 32'h0, 1'b1, 0, lat);
        check_eq("bad_idx_latency", 64'(lat), 64'd2);
        check_eq("bad_idx_no_strobe", 64'(s_hi_total + c_hi_total - hi0), 64'd0);

        // Protocol error: write and read together
        hi0 = s_hi_total + c_hi_total;
        do_req(1'b1, 1'b1, 20'h00005, 32'h11111111, 32'h0, 1'b1, 0, lat);
        check_eq("wr_rd_latency", 64'(lat), 64'd2);
        check_eq("wr_rd_no_strobe", 64'(s_hi_total + c_hi_total - hi0), 64'd0);

        // Timeout: SRAM never answers
        s_delay = -1;
        do_req(1'b0, 1'b1, 20'h00007, 32'h0, 32'h0, 1'b1, 0, lat);
        check_eq("to_latency", 64'(lat), 64'(TIMEOUT + 2));
        check_eq("to_strobe_cycles", 64'(s_last_hi), 64'(TIMEOUT));

        // Ready on the final allowed cycle wins over the timeout
        s_delay = TIMEOUT - 1;
        do_req(1'b0, 1'b1, 20'h00007, 32'h0, 32'hCAFE0007, 1'b0, 0, lat);
        check_eq("last_cycle_latency", 64'(lat), 64'(TIMEOUT + 2));

        // Reset while waiting on the target
        s_delay = -1;
        @(negedge clk);
        static_ren  = 1'b1;
        static_addr = 20'h00005;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sram_ren) begin
                first = i;
                break;
            end
        end
        check_eq("rstwait_strobe_seen", 64'(first > 0), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rstwait_sram_strb", 64'({sram_ren, sram_wen}), 64'd0);
        check_eq("rstwait_ready", 64'(static_ready), 64'd0);
        static_ren = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        s_delay = 0;
        repeat (4) @(negedge clk);
        do_req(1'b0, 1'b1, 20'h00005, 32'h0, 32'hDEADBEEF, 1'b0, 0, lat);
        check_eq("rstwait_fresh_latency", 64'(lat), 64'd3);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
